game_round_seq: RTL and testbench

//  Parametrised round/score sequencer for the cannon-vs-target game. Sits between
//  the control debouncer, trajectory calculator and target generator. Gates shots,

---
 rtl/game_pkg.sv | 30 +++
 rtl/sat_acc.sv | 38 +++
 rtl/game_round_seq.sv | 171 +++++++++++++++++
 tb/tb_game_round_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, display selects and width helpers for the round sequencer
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEW_TGT,
    ST_ARMED,
    ST_FLIGHT,
    ST_OVER
  } state_t;

  localparam logic [1:0] DISP_SCORE = 2'd0;
  localparam logic [1:0] DISP_ROUND = 2'd1;
  localparam logic [1:0] DISP_SHOTS = 2'd2;
  localparam logic [1:0] DISP_HITS  = 2'd3;

  // Widths never collapse to zero so single-round / single-cycle configs stay legal.
  function automatic int round_w(input int rounds);
    return (rounds > 1) ? $clog2(rounds) : 1;
  endfunction

  function automatic int shots_w(input int shots);
    return (shots > 0) ? $clog2(shots + 1) : 1;
  endfunction

  function automatic int timer_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/sat_acc.sv
// rtl/sat_acc.sv - saturating accumulator with clear and enable
module sat_acc #(
  parameter int W  = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          add,
  input  logic [AW-1:0] addend,
  output logic [W-1:0]  acc
);

  localparam int SUMW = ((W > AW) ? W : AW) + 1;
  localparam logic [SUMW-1:0] MAXV = {{(SUMW - W){1'b0}}, {W{1'b1}}};

  logic [SUMW-1:0] sum;
  logic [W-1:0]    sat_sum;

  always_comb begin
    sum     = SUMW'(acc) + SUMW'(addend);
    sat_sum = (sum > MAXV) ? {W{1'b1}} : sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      if (clr) begin
        acc <= '0;
      end else if (add) begin
        acc <= sat_sum;
      end
    end
  end

endmodule

// File: rtl/game_round_seq.sv
// rtl/game_round_seq.sv - round/score sequencer gating shots, requesting targets and scoring hits
module game_round_seq
  import game_pkg::*;
#(
  parameter int SHOTS_PER_ROUND = 3,
  parameter int ROUNDS          = 4,
  parameter int SCORE_W         = 8,
  parameter int FLIGHT_TIMEOUT  = 64,
  localparam int RW = round_w(ROUNDS),
  localparam int SW = shots_w(SHOTS_PER_ROUND)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start_new_game,
  input  logic               shoot_req,
  input  logic               result_valid,
  input  logic               hit,
  output logic               shoot_out,
  output logic               new_target,
  output logic               busy,
  output logic               game_over,
  output logic [RW-1:0]      round_idx,
  output logic [SW-1:0]      shots_left,
  output logic [SCORE_W-1:0] score,
  input  logic [1:0]         disp_sel,
  output logic [SCORE_W-1:0] disp_out
);

  localparam int TW = timer_w(FLIGHT_TIMEOUT);
  localparam int PW = SW + 1;

  state_t             state, state_nxt;
  logic               start_prev;
  logic               start_edge;
  logic [TW-1:0]      timer;
  logic               shoot_q;
  logic               fire;
  logic               resolve;
  logic               is_hit;
  logic               round_end;
  logic               next_round;
  logic [PW-1:0]      points;
  logic [SCORE_W-1:0] hits;

  assign start_edge = ena & start_new_game & ~start_prev;
  // shots_left is already post-decrement while in FLIGHT, so the last shot earns 1.
  assign points     = {1'b0, shots_left} + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fire       = 1'b0;
    resolve    = 1'b0;
    is_hit     = 1'b0;
    round_end  = 1'b0;
    next_round = 1'b0;
    if (ena) begin
      if (start_edge) begin
        state_nxt = ST_NEW_TGT;
      end else begin
        case (state)
          ST_IDLE:    state_nxt = ST_IDLE;
          ST_NEW_TGT: state_nxt = ST_ARMED;
          ST_ARMED: begin
            if (shoot_req) begin
              fire      = 1'b1;
              state_nxt = ST_FLIGHT;
            end
          end
          ST_FLIGHT: begin
            if (result_valid || (timer == TW'(FLIGHT_TIMEOUT - 1))) begin
              resolve   = 1'b1;
              is_hit    = result_valid & hit;
              round_end = is_hit || (shots_left == '0);
              if (!round_end) begin
                state_nxt = ST_ARMED;
              end else if (round_idx == RW'(ROUNDS - 1)) begin
                state_nxt = ST_OVER;
              end else begin
                next_round = 1'b1;
                state_nxt  = ST_NEW_TGT;
              end
            end
          end
          ST_OVER:    state_nxt = ST_OVER;
          default:    state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev <= 1'b0;
      shoot_q    <= 1'b0;
      timer      <= '0;
      round_idx  <= '0;
      shots_left <= '0;
    end else if (!ena) begin
      shoot_q <= 1'b0;
    end else begin
      start_prev <= start_new_game;
      shoot_q    <= fire;
      if (start_edge) begin
        round_idx <= '0;
        timer     <= '0;
      end else begin
        if (state == ST_NEW_TGT) begin
          shots_left <= SW'(SHOTS_PER_ROUND);
        end
        if (fire) begin
          shots_left <= shots_left - SW'(1);
          timer      <= '0;
        end else if (state == ST_FLIGHT) begin
          timer <= timer + TW'(1);
        end
        if (next_round) begin
          round_idx <= round_idx + RW'(1);
        end
      end
    end
  end

  sat_acc #(.W(SCORE_W), .AW(PW)) u_score (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena),
    .clr    (start_edge),
    .add    (resolve & is_hit),
    .addend (points),
    .acc    (score)
  );

  sat_acc #(.W(SCORE_W), .AW(1)) u_hits (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena),
    .clr    (start_edge),
    .add    (resolve & is_hit),
    .addend (1'b1),
    .acc    (hits)
  );

  // The display keeps tracking its sources even while the game is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_out <= '0;
    end else begin
      case (disp_sel)
        DISP_SCORE: disp_out <= score;
        DISP_ROUND: disp_out <= SCORE_W'(round_idx);
        DISP_SHOTS: disp_out <= SCORE_W'(shots_left);
        default:    disp_out <= hits;
      endcase
    end
  end

  assign shoot_out  = shoot_q;
  assign new_target = ena & (state == ST_NEW_TGT);
  assign busy       = (state == ST_NEW_TGT) || (state == ST_FLIGHT);
  assign game_over  = (state == ST_OVER);

endmodule

// File: tb/tb_game_round_seq.sv
// tb/tb_game_round_seq.sv - directed self-checking bench for game_round_seq
module tb_game_round_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start_new_game = 1'b0;
  logic       shoot_req = 1'b0;
  logic       result_valid = 1'b0;
  logic       hit = 1'b0;
  logic [1:0] disp_sel = 2'd0;

  logic       d0_shoot_out, d0_new_target, d0_busy, d0_game_over;
  logic [1:0] d0_round_idx, d0_shots_left;
  logic [7:0] d0_score, d0_disp_out;

  logic       d1_shoot_out, d1_new_target, d1_busy, d1_game_over;
  logic [1:0] d1_round_idx, d1_shots_left;
  logic [2:0] d1_score, d1_disp_out;

  int n_cmp = 0;
  int n_bad = 0;

  game_round_seq dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start_new_game(start_new_game),
    .shoot_req(shoot_req), .result_valid(result_valid), .hit(hit),
    .shoot_out(d0_shoot_out), .new_target(d0_new_target), .busy(d0_busy),
    .game_over(d0_game_over), .round_idx(d0_round_idx), .shots_left(d0_shots_left),
    .score(d0_score), .disp_sel(disp_sel), .disp_out(d0_disp_out)
  );

  game_round_seq #(.SCORE_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start_new_game(start_new_game),
    .shoot_req(shoot_req), .result_valid(result_valid), .hit(hit),
    .shoot_out(d1_shoot_out), .new_target(d1_new_target), .busy(d1_busy),
    .game_over(d1_game_over), .round_idx(d1_round_idx), .shots_left(d1_shots_left),
    .score(d1_score), .disp_sel(disp_sel), .disp_out(d1_disp_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire_shot();
    shoot_req = 1'b1;
    tick();
    shoot_req = 1'b0;
  endtask

  task automatic resolve(input logic h);
    result_valid = 1'b1;
    hit = h;
    tick();
    result_valid = 1'b0;
    hit = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_shoot", d0_shoot_out, 0);
    chk("rst_newtgt", d0_new_target, 0);
    chk("rst_busy", d0_busy, 0);
    chk("rst_over", d0_game_over, 0);
    chk("rst_round", d0_round_idx, 0);
    chk("rst_shots", d0_shots_left, 0);
    chk("rst_score", d0_score, 0);
    chk("rst_disp", d0_disp_out, 0);
    rst_n = 1'b1;
    tick();

    // start edge -> NEW_TGT for one cycle, then ARMED with a full magazine
    start_new_game = 1'b1;
    tick();
    chk("t1_newtgt", d0_new_target, 1);
    chk("t1_busy", d0_busy, 1);
    tick();
    chk("t1_newtgt_off", d0_new_target, 0);
    chk("t1_shots", d0_shots_left, 3);
    chk("t1_round", d0_round_idx, 0);
    chk("t1_armed_busy", d0_busy, 0);
    tick();
    tick();
    chk("t1_level_held", d0_new_target, 0);
    chk("t1_level_shots", d0_shots_left, 3);
    start_new_game = 1'b0;

    // first-shot hit five cycles after the request
    fire_shot();
    chk("t2_shoot", d0_shoot_out, 1);
    chk("t2_shots", d0_shots_left, 2);
    tick();
    chk("t2_shoot_once", d0_shoot_out, 0);
    tick();
    tick();
    tick();
    resolve(1'b1);
    chk("t2_newtgt", d0_new_target, 1);
    chk("t2_score", d0_score, 3);
    chk("t2_round", d0_round_idx, 1);
    disp_sel = 2'd3;
    tick();
    chk("t2_hits_disp", d0_disp_out, 1);
    chk("t2_reload", d0_shots_left, 3);

    // miss, miss, hit on the last shot -> one point
    fire_shot();
    resolve(1'b0);
    chk("t3_miss_shots", d0_shots_left, 2);
    chk("t3_miss_round", d0_round_idx, 1);
    fire_shot();
    resolve(1'b0);
    fire_shot();
    chk("t3_last_shots", d0_shots_left, 0);
    resolve(1'b1);
    chk("t3_score", d0_score, 4);
    chk("t3_round", d0_round_idx, 2);
    disp_sel = 2'd1;
    tick();
    chk("t3_round_disp", d0_disp_out, 2);

    // three misses -> round advances, score unchanged
    for (int i = 0; i < 3; i++) begin
      fire_shot();
      resolve(1'b0);
    end
    chk("t3_3miss_score", d0_score, 4);
    chk("t3_3miss_round", d0_round_idx, 3);
    chk("t3_3miss_newtgt", d0_new_target, 1);
    tick();

    // flight timeout after exactly 64 cycles; shoot_req in FLIGHT ignored
    fire_shot();
    chk("t4_shoot", d0_shoot_out, 1);
    for (int i = 1; i < 64; i++) begin
      if (i == 5) shoot_req = 1'b1;
      if (i == 6) begin
        shoot_req = 1'b0;
        chk("t4_no_refire", d0_shoot_out, 0);
      end
      tick();
      if (i == 63) chk("t4_busy_last", d0_busy, 1);
    end
    tick();
    chk("t4_timeout_busy", d0_busy, 0);
    chk("t4_timeout_shots", d0_shots_left, 2);
    chk("t4_timeout_score", d0_score, 4);
    chk("t4_timeout_round", d0_round_idx, 3);

    // ena low in FLIGHT: result ignored and state frozen
    fire_shot();
    tick();
    ena = 1'b0;
    resolve(1'b1);
    chk("t6_frozen_busy", d0_busy, 1);
    chk("t6_frozen_score", d0_score, 4);
    chk("t6_frozen_shots", d0_shots_left, 1);
    ena = 1'b1;
    tick();
    chk("t6_still_busy", d0_busy, 1);
    resolve(1'b1);
    chk("t6_over", d0_game_over, 1);
    chk("t6_score", d0_score, 6);
    chk("t6_over_busy", d0_busy, 0);

    // restart, then four first-shot hits: 12 on 8 bits, saturating at 7 on 3 bits
    start_new_game = 1'b1;
    tick();
    chk("t5_restart_newtgt", d0_new_target, 1);
    chk("t5_restart_score", d0_score, 0);
    chk("t5_restart_round", d0_round_idx, 0);
    chk("t5_restart_over", d0_game_over, 0);
    for (int r = 0; r < 4; r++) begin
      tick();
      fire_shot();
      resolve(1'b1);
    end
    chk("t5_score8", d0_score, 12);
    chk("t5_score3_sat", d1_score, 7);
    chk("t5_over8", d0_game_over, 1);
    chk("t5_over3", d1_game_over, 1);
    disp_sel = 2'd3;
    tick();
    chk("t5_hits3", d1_disp_out, 4);
    chk("t5_over_hold_round", d1_round_idx, 3);
    start_new_game = 1'b0;
    tick();
    start_new_game = 1'b1;
    tick();
    chk("t5_again_score", d1_score, 0);
    chk("t5_again_round", d1_round_idx, 0);
    chk("t5_again_newtgt", d1_new_target, 1);
    start_new_game = 1'b0;

    // async reset in the middle of FLIGHT
    tick();
    fire_shot();
    chk("t6_pre_rst_busy", d0_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", d0_busy, 0);
    chk("t6_rst_shoot", d0_shoot_out, 0);
    chk("t6_rst_shots", d0_shots_left, 0);
    chk("t6_rst_disp", d0_disp_out, 0);
    chk("t6_rst_over", d1_game_over, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
